// File: rtl/adc_capture_pkg.sv
// Shared types and encodings for the ADC capture write controller.
package adc_capture_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_e;

    localparam logic MODE_SINGLE = 1'b0;
    localparam logic MODE_CONT   = 1'b1;

    localparam logic SRC_EXT   = 1'b0;
    localparam logic SRC_LEVEL = 1'b1;

    localparam int EDGE_RISING  = 0;
    localparam int EDGE_FALLING = 1;

endpackage

// File: rtl/adc_capture_wr_trig_sync.sv
// Two-flop synchroniser for an asynchronous trigger plus an edge detector
// producing a one-cycle pulse on the selected edge.
module trig_sync_edge
    import adc_capture_pkg::*;
#(
    parameter int EDGE = EDGE_RISING
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic async_i,
    output logic pulse_o
);

    logic [1:0] sync_q;
    logic       edge_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= 2'b00;
            edge_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], async_i};
            edge_q <= sync_q[1];
        end
    end

    // Pulse is combinational from flops so the FSM reacts on the third edge.
    assign pulse_o = (EDGE == EDGE_FALLING) ? (~sync_q[1] & edge_q)
                                            : (sync_q[1] & ~edge_q);

endmodule

// File: rtl/adc_capture_wr.sv
// ADC capture write controller: waits for an external or level trigger, then
// writes DEPTH consecutive valid samples into the capture RAM.
module adc_capture_wr
    import adc_capture_pkg::*;
#(
    parameter int  DATA_W    = 8,
    parameter int  DEPTH     = 1024,
    parameter int  TRIG_EDGE = EDGE_RISING,
    localparam int ADDR_W    = $clog2(DEPTH)
) (
    input  logic              I_clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] ad_data,
    input  logic              ad_valid,
    input  logic              trigger,
    input  logic              arm,
    input  logic              abort,
    input  logic              mode,
    input  logic              trig_src,
    input  logic [DATA_W-1:0] threshold,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              done,
    output logic [15:0]       capture_cnt,
    output state_e            state_dbg
);

    // ad_valid is a valid-only qualifier: there is no ready, every high cycle
    // carries one sample, and a sample not accepted that cycle is dropped.

    state_e              state_q, state_d;
    logic                mode_q, mode_d;
    logic                src_q, src_d;
    logic [DATA_W-1:0]   prev_q, prev_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [15:0]         cnt_q, cnt_d;
    logic                wr_en_q;
    logic [ADDR_W-1:0]   wr_addr_q;
    logic [DATA_W-1:0]   wr_data_q;

    logic ext_pulse;
    logic level_hit;
    logic trig_event;
    logic last_wr;
    logic accept;
    logic clr_addr;

    trig_sync_edge #(
        .EDGE (TRIG_EDGE)
    ) u_trig_sync (
        .clk_i   (I_clk),
        .rst_i   (rst),
        .async_i (trigger),
        .pulse_o (ext_pulse)
    );

    always_comb begin
        level_hit = 1'b0;
        if (ad_valid) begin
            if (TRIG_EDGE == EDGE_FALLING)
                level_hit = (prev_q >= threshold) && (ad_data < threshold);
            else
                level_hit = (prev_q < threshold) && (ad_data >= threshold);
        end
    end

    assign trig_event = (src_q == SRC_LEVEL) ? level_hit : ext_pulse;
    // The final strobe is on the bus this cycle; leave CAPTURE on the next edge.
    assign last_wr    = wr_en_q && (wr_addr_q == ADDR_W'(DEPTH - 1));

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        src_d    = src_q;
        prev_d   = ad_valid ? ad_data : prev_q;
        addr_d   = addr_q;
        cnt_d    = cnt_q;
        accept   = 1'b0;
        clr_addr = 1'b0;

        if (abort) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (arm) begin
                        state_d  = ST_ARMED;
                        mode_d   = mode;
                        src_d    = trig_src;
                        addr_d   = '0;
                        clr_addr = 1'b1;
                        prev_d   = (TRIG_EDGE == EDGE_FALLING) ? '1 : '0;
                    end
                end
                ST_ARMED: begin
                    if (trig_event) begin
                        state_d = ST_CAPTURE;
                        accept  = ad_valid;
                    end
                end
                ST_CAPTURE: begin
                    if (last_wr) begin
                        cnt_d = cnt_q + 16'd1;
                        if (mode_q == MODE_CONT) begin
                            state_d  = ST_ARMED;
                            addr_d   = '0;
                            clr_addr = 1'b1;
                        end else begin
                            state_d = ST_DONE;
                        end
                    end else begin
                        accept = ad_valid;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        if (accept)
            addr_d = addr_q + 1'b1;
    end

    always_ff @(posedge I_clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            mode_q  <= MODE_SINGLE;
            src_q   <= SRC_EXT;
            prev_q  <= '0;
            addr_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            src_q   <= src_d;
            prev_q  <= prev_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge I_clk or posedge rst) begin
        if (rst) begin
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            wr_en_q <= accept;
            if (accept) begin
                wr_addr_q <= addr_q;
                wr_data_q <= ad_data;
            end else if (clr_addr) begin
                wr_addr_q <= '0;
            end
        end
    end

    assign wr_en       = wr_en_q;
    assign wr_addr     = wr_addr_q;
    assign wr_data     = wr_data_q;
    assign busy        = (state_q == ST_ARMED) || (state_q == ST_CAPTURE);
    assign done        = (state_q == ST_DONE);
    assign capture_cnt = cnt_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_adc_capture_wr.sv
// Self-checking bench for adc_capture_wr with DEPTH=16, rising-edge triggers.
module tb_adc_capture_wr;
  import adc_capture_pkg::*;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  ad_data = 8'h00;
  logic        ad_valid = 1'b0;
  logic        trigger = 1'b0;
  logic        arm = 1'b0;
  logic        abort = 1'b0;
  logic        mode = 1'b0;
  logic        trig_src = 1'b0;
  logic [7:0]  threshold = 8'h00;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [7:0]  wr_data;
  logic        busy;
  logic        done;
  logic [15:0] capture_cnt;
  state_e      state_dbg;

  adc_capture_wr #(.DATA_W(8), .DEPTH(DEPTH), .TRIG_EDGE(EDGE_RISING)) dut (
    .I_clk(clk), .rst(rst), .ad_data(ad_data), .ad_valid(ad_valid),
    .trigger(trigger), .arm(arm), .abort(abort), .mode(mode),
    .trig_src(trig_src), .threshold(threshold), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .done(done),
    .capture_cnt(capture_cnt), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int edge_n = 0;
  int vpat = 0;
  int dmode = 0;
  logic [7:0] ramp = 8'h00;
  int exp_cnt = 0;

  int         v_edge[$];
  logic [7:0] v_data[$];
  logic [7:0] dir_q[$];
  int         o_edge[$];
  logic [3:0] o_addr[$];
  logic [7:0] o_data[$];
  int         e_edge[$];
  logic [3:0] e_addr[$];
  logic [7:0] e_data[$];
  int         done_edge = -1;
  int         done_seen = 0;
  logic       done_prev = 1'b0;

  always @(posedge clk) edge_n++;

  // sample driver: logs every valid sample with the edge that samples it
  always @(negedge clk) begin
    if (dir_q.size() != 0) begin
      ad_valid = 1'b1;
      ad_data = dir_q.pop_front();
    end else begin
      case (vpat)
        0: ad_valid = 1'b0;
        1: ad_valid = 1'b1;
        2: ad_valid = ~ad_valid;
        default: ad_valid = 1'($urandom_range(0, 1));
      endcase
      if (dmode == 1) begin
        ad_data = ramp;
        if (ad_valid) ramp++;
      end else begin
        ad_data = 8'($urandom_range(0, 255));
      end
    end
    if (ad_valid) begin
      v_edge.push_back(edge_n + 1);
      v_data.push_back(ad_data);
    end
  end

  // write monitor
  always @(posedge clk) begin
    #1;
    if (wr_en === 1'b1) begin
      o_edge.push_back(edge_n);
      o_addr.push_back(wr_addr);
      o_data.push_back(wr_data);
    end
    if (done === 1'b1 && !done_prev) begin
      done_edge = edge_n;
      done_seen++;
    end
    done_prev = done;
  end

  // reference model: ext trigger driven before edge t is acted on at edge t+2;
  // the first DEPTH valid samples from then on land at addresses 0..DEPTH-1
  function automatic void model_ext(input int t);
    int n = 0;
    foreach (v_edge[i]) begin
      if (v_edge[i] >= t + 2 && n < DEPTH) begin
        e_edge.push_back(v_edge[i]);
        e_data.push_back(v_data[i]);
        e_addr.push_back(4'(n));
        n++;
      end
    end
  endfunction

  // reference model: level crossing among samples after the arm edge
  function automatic void model_level(input int a, input logic [7:0] th);
    logic [7:0] prev = 8'h00;
    bit hit = 0;
    int n = 0;
    foreach (v_edge[i]) begin
      if (v_edge[i] > a) begin
        if (!hit && prev < th && v_data[i] >= th) hit = 1;
        if (hit && n < DEPTH) begin
          e_edge.push_back(v_edge[i]);
          e_data.push_back(v_data[i]);
          e_addr.push_back(4'(n));
          n++;
        end
        prev = v_data[i];
      end
    end
  endfunction

  // driver tasks
  task automatic clear_logs();
    @(posedge clk);
    #2;
    v_edge.delete(); v_data.delete();
    o_edge.delete(); o_addr.delete(); o_data.delete();
    e_edge.delete(); e_addr.delete(); e_data.delete();
    done_seen = 0;
    done_edge = -1;
  endtask

  task automatic do_arm(input logic m, input logic src, output int a);
    @(negedge clk);
    arm = 1'b1; mode = m; trig_src = src;
    a = edge_n + 1;
    @(negedge clk);
    arm = 1'b0;
  endtask

  task automatic pulse_trigger(output int t);
    @(negedge clk);
    trigger = 1'b1;
    t = edge_n + 1;
    repeat (3) @(negedge clk);
    trigger = 1'b0;
  endtask

  task automatic wait_writes(input int n, input int budget);
    int b = budget;
    while (o_addr.size() < n && b > 0) begin
      @(negedge clk);
      b--;
    end
    if (o_addr.size() < n) begin
      checks++; failures++;
      $display("FAIL wait_writes: got %0d writes, required %0d within %0d cycles", o_addr.size(), n, budget);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (wr_en !== 1'b0) begin failures++; $display("FAIL reset_wr_en: got %b want 0", wr_en); end
    checks++; if (wr_addr !== 4'd0) begin failures++; $display("FAIL reset_wr_addr: got %0d want 0", wr_addr); end
    checks++; if (wr_data !== 8'd0) begin failures++; $display("FAIL reset_wr_data: got %0h want 0", wr_data); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (capture_cnt !== 16'd0) begin failures++; $display("FAIL reset_cnt: got %0d want 0", capture_cnt); end
    checks++; if (state_dbg !== ST_IDLE) begin failures++; $display("FAIL reset_state: got %0d want IDLE", state_dbg); end
    rst = 1'b0;
  endtask

  task automatic test_single_ext();
    int a, t;
    vpat = 1; dmode = 1;
    clear_logs();
    do_arm(MODE_SINGLE, SRC_EXT, a);
    pulse_trigger(t);
    wait_writes(DEPTH, 200);
    repeat (5) @(negedge clk);
    model_ext(t);
    exp_cnt++;
    checks++; if (o_addr.size() != e_addr.size()) begin failures++; $display("FAIL single_count: got %0d want %0d", o_addr.size(), e_addr.size()); end
    for (int i = 0; i < o_addr.size() && i < e_addr.size(); i++) begin
      checks++;
      if (o_addr[i] !== e_addr[i] || o_data[i] !== e_data[i] || o_edge[i] != e_edge[i]) begin
        failures++;
        $display("FAIL single_write[%0d]: got a=%0d d=%0h e=%0d want a=%0d d=%0h e=%0d", i, o_addr[i], o_data[i], o_edge[i], e_addr[i], e_data[i], e_edge[i]);
      end
    end
    checks++; if (done !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL single_done: got done=%b busy=%b want 1/0", done, busy); end
    if (o_edge.size() > 0) begin
      checks++;
      if (done_edge != o_edge[o_edge.size()-1] + 1) begin failures++; $display("FAIL single_done_timing: got edge %0d want %0d", done_edge, o_edge[o_edge.size()-1] + 1); end
    end
    checks++; if (capture_cnt !== 16'(exp_cnt)) begin failures++; $display("FAIL single_cnt: got %0d want %0d", capture_cnt, exp_cnt); end
  endtask

  task automatic test_level();
    int a;
    logic [7:0] th;
    for (int run = 0; run < 2; run++) begin
      th = (run == 0) ? 8'h80 : 8'($urandom_range(1, 254));
      threshold = th;
      vpat = 0; dmode = 0;
      clear_logs();
      do_arm(MODE_SINGLE, SRC_LEVEL, a);
      @(negedge clk);
      if (run == 0) begin
        dir_q.push_back(8'h70); dir_q.push_back(8'h7F);
        dir_q.push_back(8'h80); dir_q.push_back(8'h90);
      end
      vpat = 3;
      wait_writes(DEPTH, 3000);
      repeat (4) @(negedge clk);
      model_level(a, th);
      exp_cnt++;
      checks++; if (o_addr.size() != e_addr.size()) begin failures++; $display("FAIL level_count[%0d]: got %0d want %0d", run, o_addr.size(), e_addr.size()); end
      for (int i = 0; i < o_addr.size() && i < e_addr.size(); i++) begin
        checks++;
        if (o_addr[i] !== e_addr[i] || o_data[i] !== e_data[i] || o_edge[i] != e_edge[i]) begin
          failures++;
          $display("FAIL level_write[%0d][%0d]: got a=%0d d=%0h e=%0d want a=%0d d=%0h e=%0d", run, i, o_addr[i], o_data[i], o_edge[i], e_addr[i], e_data[i], e_edge[i]);
        end
      end
      if (run == 0 && o_data.size() > 0) begin
        checks++; if (o_data[0] !== 8'h80) begin failures++; $display("FAIL level_first: got %0h want 80", o_data[0]); end
      end
      checks++; if (capture_cnt !== 16'(exp_cnt)) begin failures++; $display("FAIL level_cnt[%0d]: got %0d want %0d", run, capture_cnt, exp_cnt); end
    end
  endtask

  task automatic test_continuous();
    int a, t;
    int tq[$];
    vpat = 3; dmode = 0;
    clear_logs();
    do_arm(MODE_CONT, SRC_EXT, a);
    for (int j = 0; j < 3; j++) begin
      pulse_trigger(t);
      tq.push_back(t);
      wait_writes(DEPTH * (j + 1), 500);
      repeat (4) @(negedge clk);
    end
    foreach (tq[j]) model_ext(tq[j]);
    exp_cnt += 3;
    checks++; if (o_addr.size() != 3 * DEPTH) begin failures++; $display("FAIL cont_count: got %0d want %0d", o_addr.size(), 3 * DEPTH); end
    for (int i = 0; i < o_addr.size() && i < e_addr.size(); i++) begin
      checks++;
      if (o_addr[i] !== e_addr[i] || o_data[i] !== e_data[i] || o_edge[i] != e_edge[i]) begin
        failures++;
        $display("FAIL cont_write[%0d]: got a=%0d d=%0h e=%0d want a=%0d d=%0h e=%0d", i, o_addr[i], o_data[i], o_edge[i], e_addr[i], e_data[i], e_edge[i]);
      end
    end
    checks++; if (done_seen != 0) begin failures++; $display("FAIL cont_done: done rose %0d times want 0", done_seen); end
    checks++; if (capture_cnt !== 16'(exp_cnt)) begin failures++; $display("FAIL cont_cnt: got %0d want %0d", capture_cnt, exp_cnt); end
    checks++; if (state_dbg !== ST_ARMED || busy !== 1'b1) begin failures++; $display("FAIL cont_rearm: got state=%0d busy=%b want ARMED/1", state_dbg, busy); end
    @(negedge clk); abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    checks++; if (state_dbg !== ST_IDLE) begin failures++; $display("FAIL cont_abort: got state=%0d want IDLE", state_dbg); end
  endtask

  task automatic test_abort();
    int a, t;
    vpat = 2; dmode = 0;
    clear_logs();
    do_arm(MODE_SINGLE, SRC_EXT, a);
    pulse_trigger(t);
    wait_writes(5, 200);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    repeat (10) @(negedge clk);
    checks++; if (o_addr.size() != 5) begin failures++; $display("FAIL abort_writes: got %0d want 5", o_addr.size()); end
    checks++; if (state_dbg !== ST_IDLE || busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL abort_state: got state=%0d busy=%b done=%b want IDLE/0/0", state_dbg, busy, done); end
    checks++; if (capture_cnt !== 16'(exp_cnt)) begin failures++; $display("FAIL abort_cnt: got %0d want %0d", capture_cnt, exp_cnt); end
  endtask

  task automatic test_trigger_ignored();
    int a, t, td;
    vpat = 1; dmode = 1;
    clear_logs();
    pulse_trigger(td);
    repeat (15) @(negedge clk);
    checks++; if (o_addr.size() != 0 || state_dbg !== ST_IDLE) begin failures++; $display("FAIL idle_trigger: got writes=%0d state=%0d want 0/IDLE", o_addr.size(), state_dbg); end
    do_arm(MODE_SINGLE, SRC_EXT, a);
    pulse_trigger(t);
    wait_writes(5, 100);
    pulse_trigger(td);
    @(negedge clk); arm = 1'b1; mode = MODE_CONT;
    @(negedge clk); arm = 1'b0;
    wait_writes(DEPTH, 100);
    repeat (5) @(negedge clk);
    pulse_trigger(td);
    repeat (15) @(negedge clk);
    model_ext(t);
    exp_cnt++;
    checks++; if (o_addr.size() != DEPTH) begin failures++; $display("FAIL ign_count: got %0d want %0d", o_addr.size(), DEPTH); end
    for (int i = 0; i < o_addr.size() && i < e_addr.size(); i++) begin
      checks++;
      if (o_addr[i] !== e_addr[i] || o_data[i] !== e_data[i]) begin
        failures++;
        $display("FAIL ign_write[%0d]: got a=%0d d=%0h want a=%0d d=%0h", i, o_addr[i], o_data[i], e_addr[i], e_data[i]);
      end
    end
    checks++; if (state_dbg !== ST_DONE || done !== 1'b1) begin failures++; $display("FAIL ign_state: got state=%0d done=%b want DONE/1", state_dbg, done); end
    checks++; if (capture_cnt !== 16'(exp_cnt)) begin failures++; $display("FAIL ign_cnt: got %0d want %0d", capture_cnt, exp_cnt); end
  endtask

  task automatic test_reset_mid_capture();
    int a, t;
    vpat = 1; dmode = 1;
    clear_logs();
    do_arm(MODE_CONT, SRC_EXT, a);
    for (int j = 0; j < 3; j++) begin
      pulse_trigger(t);
      wait_writes((j < 2) ? DEPTH * (j + 1) : 37, 300);
      if (j < 2) repeat (3) @(negedge clk);
    end
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    exp_cnt = 0;
    checks++;
    if (wr_en !== 1'b0 || wr_addr !== 4'd0 || wr_data !== 8'd0 || busy !== 1'b0 || done !== 1'b0 || capture_cnt !== 16'd0 || state_dbg !== ST_IDLE) begin
      failures++;
      $display("FAIL midreset_outputs: got en=%b a=%0d d=%0h busy=%b done=%b cnt=%0d st=%0d want all 0/IDLE", wr_en, wr_addr, wr_data, busy, done, capture_cnt, state_dbg);
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    clear_logs();
    pulse_trigger(t);
    repeat (10) @(negedge clk);
    pulse_trigger(t);
    repeat (10) @(negedge clk);
    checks++; if (o_addr.size() != 0 || state_dbg !== ST_IDLE) begin failures++; $display("FAIL midreset_quiet: got writes=%0d state=%0d want 0/IDLE", o_addr.size(), state_dbg); end
    do_arm(MODE_SINGLE, SRC_EXT, a);
    pulse_trigger(t);
    wait_writes(DEPTH, 200);
    repeat (4) @(negedge clk);
    exp_cnt++;
    checks++; if (capture_cnt !== 16'(exp_cnt) || done !== 1'b1) begin failures++; $display("FAIL midreset_rearm: got cnt=%0d done=%b want %0d/1", capture_cnt, done, exp_cnt); end
    if (o_addr.size() > 0) begin
      checks++; if (o_addr[0] !== 4'd0) begin failures++; $display("FAIL midreset_addr0: got %0d want 0", o_addr[0]); end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_ext();
    test_level();
    test_continuous();
    test_abort();
    test_trigger_ignored();
    test_reset_mid_capture();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
